// File: rtl/uart_pkg.sv
// Shared types and defaults for the buffered UART transmitter.
// Frame state encoding and build-time defaults live here.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 5208;
    localparam int UART_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte buffer between the bus handshake and the frame FSM.
// Registered pointers and count; read data comes from storage only.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int DW    = UART_DATA_BITS,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    // Full is judged on the registered count, so a pop on the same
    // edge never frees a slot for a push.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Buffered 8N1 UART transmitter: FIFO, frame FSM, baud counter.
// Line, busy and done are registered from next-state values.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = UART_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       UART_TX,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [2:0] fifo_count
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state;
    uart_tx_state_t state_next;

    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_next;
    logic [7:0]    shreg;
    logic [7:0]    shreg_next;

    logic line_q;
    logic line_next;
    logic busy_q;
    logic busy_next;
    logic done_q;
    logic done_next;

    logic          tick;
    logic          pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign tick       = (baud_cnt == BAUD_LAST);
    assign tx_ready   = !fifo_full;
    assign fifo_count = 3'(fifo_cnt);
    assign UART_TX    = line_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

    // State register plus datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            line_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shreg    <= shreg_next;
            line_q   <= line_next;
            busy_q   <= busy_next;
            done_q   <= done_next;
        end
    end

    // Next-state, baud/bit counters, shifter and FIFO pop request.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + BW'(1);
        bit_next   = bit_idx;
        shreg_next = shreg;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    state_next = START;
                    pop        = 1'b1;
                    shreg_next = fifo_rdata;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    baud_next  = '0;
                    bit_next   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    baud_next = '0;
                    if (bit_idx == BIT_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        shreg_next = shreg >> 1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        state_next = START;
                        pop        = 1'b1;
                        shreg_next = fifo_rdata;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
            end
        endcase
    end

    // Output values for the coming cycle, taken from the next state
    // so the registered line changes exactly on bit boundaries.
    always_comb begin
        line_next = 1'b1;
        busy_next = (state_next != IDLE);
        done_next = (state == STOP) && tick;
        unique case (state_next)
            IDLE:    line_next = 1'b1;
            START:   line_next = 1'b0;
            DATA:    line_next = shreg_next[0];
            STOP:    line_next = 1'b1;
            default: line_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT=4.
// A line receiver collects transmitted bytes for order checks.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       UART_TX;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    logic [7:0] rx_q[$];
    logic [7:0] rx_byte;

    uart_tx_ctrl #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .UART_TX    (UART_TX),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count tx_done pulses.
    always @(posedge clk) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Line receiver: sample mid-bit after each start-bit fall.
    always begin
        @(negedge UART_TX);
        if (!reset) begin
            repeat (2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(posedge clk);
                #1;
                rx_byte[i] = UART_TX;
            end
            rx_q.push_back(rx_byte);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Called just after the start-bit edge S; returns just after S+40.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        chk({tag, "_start"}, UART_TX, 1'b0);
        chk({tag, "_busy0"}, tx_busy, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            tick();
            chk($sformatf("%s_bit%0d", tag, k), UART_TX, f[k]);
            chk($sformatf("%s_nodone%0d", tag, k), tx_done, 1'b0);
            tick();
            tick();
        end
    endtask

    initial begin
        int   d0;
        int   w;
        logic low;
        logic busy_seen;

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tick();
        tick();
        chk("rst_line", UART_TX, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        reset = 1'b0;
        tick();
        chk("idle_line", UART_TX, 1'b1);
        chk("idle_busy", tx_busy, 1'b0);

        // single byte
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        chk("a5_acc_count", fifo_count, 3'd1);
        chk("a5_acc_line", UART_TX, 1'b1);
        tx_valid = 1'b0;
        d0 = done_cnt;
        tick();
        chk("a5_pop_count", fifo_count, 3'd0);
        check_frame(8'hA5, "a5");
        chk("a5_done", tx_done, 1'b1);
        chk("a5_busy_end", tx_busy, 1'b0);
        chk("a5_line_end", UART_TX, 1'b1);
        tick();
        chk("a5_done_low", tx_done, 1'b0);
        chk("a5_done_once", done_cnt - d0, 1);

        // back-to-back
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'h0F;
        tick();
        tx_valid = 1'b0;
        chk("b2b_count", fifo_count, 3'd1);
        d0 = done_cnt;
        check_frame(8'h55, "b55");
        chk("b55_done", tx_done, 1'b1);
        chk("b55_busy", tx_busy, 1'b1);
        check_frame(8'h0F, "b0f");
        chk("b0f_done", tx_done, 1'b1);
        chk("b0f_busy", tx_busy, 1'b0);
        tick();
        chk("b2b_pulses", done_cnt - d0, 2);

        // full FIFO
        rx_q.delete();
        d0 = done_cnt;
        tx_valid = 1'b1;
        tx_data  = 8'h01;
        tick();
        chk("full_c1", fifo_count, 3'd1);
        tx_data = 8'h02;
        tick();
        chk("full_c2", fifo_count, 3'd1);
        chk("full_start", UART_TX, 1'b0);
        tx_data = 8'h03;
        tick();
        chk("full_c3", fifo_count, 3'd2);
        tx_data = 8'h04;
        tick();
        chk("full_c4", fifo_count, 3'd3);
        tx_data = 8'h05;
        tick();
        chk("full_c5", fifo_count, 3'd4);
        chk("full_ready", tx_ready, 1'b0);
        tx_data = 8'h06;
        w = 0;
        while (!tx_ready && w < 100) begin
            tick();
            w++;
        end
        chk("full_wait", w, 37);
        chk("full_refused", fifo_count, 3'd3);
        tick();
        chk("full_acc6", fifo_count, 3'd4);
        tx_valid = 1'b0;
        w = 0;
        while ((tx_busy || fifo_count != 3'd0) && w < 400) begin
            tick();
            w++;
        end
        chk("drain_bound", (w < 400), 1'b1);
        repeat (4) tick();
        chk("full_rx_n", rx_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("full_rx%0d", i), rx_q[i], i + 1);
        end
        chk("full_dones", done_cnt - d0, 6);

        // reset mid-frame
        d0 = done_cnt;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tx_data = 8'h11;
        tick();
        tx_data = 8'h22;
        tick();
        tx_valid = 1'b0;
        chk("rm_count", fifo_count, 3'd2);
        repeat (16) tick();
        chk("rm_busy_pre", tx_busy, 1'b1);
        reset = 1'b1;
        tick();
        chk("rm_line", UART_TX, 1'b1);
        chk("rm_count0", fifo_count, 3'd0);
        chk("rm_busy", tx_busy, 1'b0);
        chk("rm_ready", tx_ready, 1'b1);
        chk("rm_done", tx_done, 1'b0);
        reset = 1'b0;
        low = 1'b0;
        busy_seen = 1'b0;
        repeat (60) begin
            tick();
            if (!UART_TX) low = 1'b1;
            if (tx_busy) busy_seen = 1'b1;
        end
        chk("rm_no_frame", low, 1'b0);
        chk("rm_no_busy", busy_seen, 1'b0);
        chk("rm_no_done", done_cnt - d0, 0);
        chk("rm_count_end", fifo_count, 3'd0);

        // held data
        rx_q.delete();
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'hC3;
        tick();
        check_frame(8'h3C, "held");
        chk("held_done", tx_done, 1'b1);
        repeat (2) tick();
        chk("held_rx_n", rx_q.size(), 1);
        chk("held_rx", rx_q[0], 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Buffered 8N1 UART transmitter driving the board-level `UART_TX` pin of the pipeline CPU's peripheral bus. It is the sending counterpart of the CPU's UART receive path. The CPU store unit, or a bench acting as the far-end host, pushes bytes through a valid/ready handshake into a 4-entry FIFO. A frame FSM then serialises each byte at a fixed baud rate, LSB first.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per serial bit (50 MHz / 9600 baud). Must be ≥ 2.
- `FIFO_DEPTH`, default 4: byte buffer entries. Must be a power of two.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `tx_data`  in  8  byte to enqueue.
- `tx_valid`  in  1  enqueue request.
- `tx_ready`  out  1  FIFO not full; a byte is accepted on an edge where `tx_valid && tx_ready`.
- `UART_TX`  out  1  serial line; idle high.
- `tx_busy`  out  1  a frame is on the line (FSM not IDLE).
- `tx_done`  out  1  one-cycle pulse at the end of each stop bit.
- `fifo_count`  out  3  current FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- **Reset values:**
  - `UART_TX`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, `fifo_count`=0.
  - FSM in IDLE; bit counter and baud counter cleared.
- **Reset mid-frame:**
  - Aborts the frame; `UART_TX`=1 after that edge.
  - Flushes the FIFO; no `tx_done` is emitted.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. On that edge: pop the head into an 8-bit shift register and drive `UART_TX`=0.
  - START → DATA after `CLKS_PER_BIT` cycles. `UART_TX`=shreg[0].
  - DATA: every `CLKS_PER_BIT` cycles, shift right and advance the bit index 0..7. After bit 7's period, go to STOP with `UART_TX`=1.
  - STOP → IDLE after `CLKS_PER_BIT` cycles, with `tx_done`=1 for that cycle.
  - STOP → START back-to-back on the same edge if the FIFO is non-empty. This also pulses `tx_done` and pops the next byte. There is no extra idle cycle between frames.
- **Baud counter:**
  - Counts 0..`CLKS_PER_BIT`-1 and reloads to 0 on every state/bit transition.
  - Width is $clog2(CLKS_PER_BIT).
- **FIFO:**
  - `tx_ready` = (count != FIFO_DEPTH) and depends only on count.
  - When full, a write is refused even if a pop occurs on the same edge.
  - A push and pop on the same edge leave the count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- `tx_data` is sampled only on an accepting edge. Later changes do not affect queued bytes.

## Timing
- **Accept latency:**
  - Byte accepted at edge E with the FIFO empty and the FSM in IDLE.
  - The FIFO is non-empty after E.
  - The FSM pops at E+1, so `UART_TX` falls after edge E+1.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles from the start-bit fall to the end of the stop bit.
- **Bit timing:** each bit holds for exactly `CLKS_PER_BIT` cycles.
- **Output registration:**
  - `UART_TX`, `tx_busy` and `tx_done` are registered; `UART_TX` is glitch-free.
  - `tx_ready` and `fifo_count` are registered from count.
- **`tx_busy`:**
  - High from the start-bit edge through the last stop-bit cycle.
  - Stays high across back-to-back frames.

## Structure
- **Package `uart_pkg`:**
  - State enum `uart_tx_state_t` {IDLE, START, DATA, STOP}.
  - `UART_DATA_BITS`=8.
  - Default `UART_CLKS_PER_BIT` and `UART_FIFO_DEPTH`.
- **Sub-module `uart_tx_fifo`:**
  - Synchronous FIFO with push/pop, full/empty and count.
  - Registered pointers; no bypass path.
- **Top level:** the FSM, baud counter and shift register.

## Test plan
Bench parameters: `CLKS_PER_BIT`=4.
- **Reset:** assert `reset` for 2 cycles → `UART_TX`=1, `tx_ready`=1, `tx_busy`=0, `fifo_count`=0.
- **Single byte:** push 0xA5 at edge E.
  - `UART_TX` falls after E+1.
  - Line samples every 4 cycles read 0,1,0,1,0,0,1,0,1,1.
  - `tx_done` pulses once at cycle E+41; `tx_busy` drops after it.
- **Back-to-back:** push 0x55 then 0x0F on consecutive cycles.
  - Two contiguous 40-cycle frames, with no idle-high cycle between the stop bit and the second start bit.
  - Two `tx_done` pulses, 40 cycles apart.
- **Full FIFO:** hold `tx_valid` with bytes 0x01..0x06 while idle.
  - Byte 0x01 is popped at once; 0x02..0x05 fill the FIFO.
  - `tx_ready`=0 with `fifo_count`=4; 0x06 is accepted only after the next pop.
  - All six bytes are transmitted in order.
- **Reset mid-frame:** assert `reset` during the DATA bit 3 of 0xFF with 2 bytes queued.
  - `UART_TX`=1 on the next edge; `fifo_count`=0.
  - No `tx_done`; no further frames.
- **Held data:** change `tx_data` while `tx_valid`=0 after an accept → the transmitted byte equals the accepted value.
